// File: rtl/alu_mult_seq.sv
// Shift-and-add 16x16 unsigned multiply (low 16 bits) that borrows the shared
// execute-stage ALU for every add and shift.
module alu_mult_seq #(
    parameter logic [3:0] OPER_ADD = 4'h0,
    parameter logic [3:0] OPER_SLL = 4'h5,
    parameter logic [3:0] OPER_SRL = 4'h7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        err,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [15:0] alu_A,
    output logic [15:0] alu_B,
    output logic [3:0]  alu_oper,
    output logic        alu_c_in,
    output logic        alu_inv_A,
    output logic        alu_inv_B,
    output logic        alu_sign,
    input  logic [15:0] alu_out,
    input  logic        alu_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EVAL = 3'd1,
        ADD  = 3'd2,
        SHL  = 3'd3,
        SRL  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] mcand, mplier, prod;

    assign alu_c_in  = 1'b0;
    assign alu_inv_A = 1'b0;
    assign alu_inv_B = 1'b0;
    assign alu_sign  = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = EVAL;
            EVAL: begin
                if (mplier == 16'h0)  state_nxt = DONE;
                else if (mplier[0])   state_nxt = ADD;
                else                  state_nxt = SHL;
            end
            ADD:  if (alu_gnt) state_nxt = alu_err ? DONE : SHL;
            SHL:  if (alu_gnt) state_nxt = alu_err ? DONE : SRL;
            SRL:  if (alu_gnt) state_nxt = alu_err ? DONE : EVAL;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        alu_req  = 1'b0;
        alu_A    = 16'h0;
        alu_B    = 16'h0;
        alu_oper = 4'h0;
        case (state)
            ADD: begin
                alu_req  = 1'b1;
                alu_A    = prod;
                alu_B    = mcand;
                alu_oper = OPER_ADD;
            end
            SHL: begin
                alu_req  = 1'b1;
                alu_A    = mcand;
                alu_B    = 16'h0001;
                alu_oper = OPER_SLL;
            end
            SRL: begin
                alu_req  = 1'b1;
                alu_A    = mplier;
                alu_B    = 16'h0001;
                alu_oper = OPER_SRL;
            end
            default: ;
        endcase
    end

    // result is loaded on the edge into DONE so it is already valid while done is high;
    // an ALU error keeps the partial product and drops the faulting write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= 16'h0;
            mplier <= 16'h0;
            prod   <= 16'h0;
            result <= 16'h0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand  <= a;
                    mplier <= b;
                    prod   <= 16'h0;
                    err    <= 1'b0;
                end
                EVAL: if (mplier == 16'h0) result <= prod;
                ADD: if (alu_gnt) begin
                    if (alu_err) begin
                        err    <= 1'b1;
                        result <= prod;
                    end else begin
                        prod <= alu_out;
                    end
                end
                SHL: if (alu_gnt) begin
                    if (alu_err) begin
                        err    <= 1'b1;
                        result <= prod;
                    end else begin
                        mcand <= alu_out;
                    end
                end
                SRL: if (alu_gnt) begin
                    if (alu_err) begin
                        err    <= 1'b1;
                        result <= prod;
                    end else begin
                        mplier <= alu_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq: behavioural ALU, table vectors, hand corner sequences
// and randomized multiplies with random grant stalls against a product/latency model.
module tb_alu_mult_seq;

    logic        clk = 1'b0;
    logic        rst, start, busy, done, err, alu_req, alu_gnt, alu_err;
    logic        alu_c_in, alu_inv_A, alu_inv_B, alu_sign;
    logic [15:0] a, b, result, alu_A, alu_B, alu_out;
    logic [3:0]  alu_oper;

    int n_chk = 0;
    int n_pass = 0;
    int viol = 0;
    logic        tr_req [0:299];
    logic [15:0] tr_A   [0:299];
    logic [15:0] tr_B   [0:299];

    always #5 clk = ~clk;

    alu_mult_seq dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .err(err),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_A(alu_A), .alu_B(alu_B),
        .alu_oper(alu_oper), .alu_c_in(alu_c_in), .alu_inv_A(alu_inv_A),
        .alu_inv_B(alu_inv_B), .alu_sign(alu_sign), .alu_out(alu_out),
        .alu_err(alu_err)
    );

    // Shared ALU as seen by the execute stage
    always_comb begin
        case (alu_oper)
            4'h0:    alu_out = alu_A + alu_B;
            4'h5:    alu_out = alu_A << alu_B[3:0];
            4'h7:    alu_out = alu_A >> alu_B[3:0];
            default: alu_out = 16'h0;
        endcase
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic int model_lat(input logic [15:0] bv);
        int l = 0;
        int pc = 0;
        for (int i = 0; i < 16; i++) if (bv[i]) begin l = i + 1; pc++; end
        return 2 + 3 * l + pc;
    endfunction

    function automatic logic [15:0] model_prod(input logic [15:0] av, input logic [15:0] bv);
        logic [31:0] full;
        full = {16'h0, av} * {16'h0, bv};
        return full[15:0];
    endfunction

    // Runs one multiply from IDLE; cyc is the cycle (counted from the start edge) where done is seen.
    task automatic do_mul(input logic [15:0] ta, input logic [15:0] tbv, input int stall_pct,
                          input int hold_first, input int err_at, input int repulse_at,
                          output logic [15:0] r, output logic e, output int cyc, output int stalls);
        int  gcount = 0;
        int  reqs = 0;
        bit  seen = 0;
        r = 16'h0; e = 1'b0; stalls = 0;
        start = 1'b1; a = ta; b = tbv; alu_gnt = 1'b0; alu_err = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; a = 16'($urandom); b = 16'($urandom);
        cyc = 1;
        while (cyc < 300 && !seen) begin
            tr_req[cyc] = alu_req; tr_A[cyc] = alu_A; tr_B[cyc] = alu_B;
            if (alu_c_in | alu_inv_A | alu_inv_B | alu_sign) viol++;
            if (!alu_req && (alu_A != 16'h0 || alu_B != 16'h0 || alu_oper != 4'h0)) viol++;
            if (done) begin
                seen = 1; r = result; e = err;
                if (alu_req || !busy) viol++;
            end else begin
                if (!busy) viol++;
                start = (cyc == repulse_at);
                alu_gnt = 1'b0; alu_err = 1'b0;
                if (alu_req) begin
                    alu_gnt = (reqs >= hold_first) && ($urandom_range(99) >= stall_pct);
                    reqs++;
                    if (!alu_gnt) stalls++;
                    else begin
                        alu_err = (gcount == err_at);
                        gcount++;
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0; alu_gnt = 1'b0; alu_err = 1'b0;
        if (!seen) begin
            $display("FAIL timeout: done not seen after %0d cycles, expected within 300", cyc);
            n_chk++;
            rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        end else begin
            @(posedge clk); #1;
            if (busy || done) viol++;
        end
    endtask

    initial begin
        vec_t        vecs[8];
        logic [15:0] r, ra, rb;
        logic        e;
        int          cyc, st, found;
        logic [9:0]  exp_req, got_req;

        vecs[0] = '{16'd3,    16'd5,    16'h000F, 13};
        vecs[1] = '{16'h1234, 16'h0000, 16'h0000, 2};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0001, 66};
        vecs[3] = '{16'd6,    16'd7,    16'h002A, 14};
        vecs[4] = '{16'h0000, 16'h8000, 16'h0000, 51};
        vecs[5] = '{16'h0100, 16'h0100, 16'h0000, 30};
        vecs[6] = '{16'hFFFE, 16'h0002, 16'hFFFC, 9};
        vecs[7] = '{16'hFFFD, 16'h0005, 16'hFFF1, 13};

        rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; alu_gnt = 1'b0; alu_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_req", int'(alu_req), 0);
        chk("reset_alu_ops", int'({alu_A, alu_B, alu_oper}), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_mul(vecs[i].a, vecs[i].b, 0, 0, -1, -1, r, e, cyc, st);
            chk($sformatf("vec%0d_result", i), int'(r), int'(vecs[i].res));
            chk($sformatf("vec%0d_latency", i), cyc, vecs[i].lat);
            chk($sformatf("vec%0d_err", i), int'(e), 0);
        end

        // alu_req pattern for 3*5 from cycle 2 (first cycle after EVAL)
        do_mul(16'd3, 16'd5, 0, 0, -1, -1, r, e, cyc, st);
        exp_req = 10'b1110110111;
        for (int k = 0; k < 10; k++) got_req[9 - k] = tr_req[2 + k];
        chk("req_pattern", int'(got_req), int'(exp_req));
        for (int k = 12; k <= 13; k++) chk($sformatf("no_req_c%0d", k), int'(tr_req[k]), 0);

        // b=0: never touches the ALU
        do_mul(16'h1234, 16'h0, 0, 0, -1, -1, r, e, cyc, st);
        chk("b0_req_c1", int'(tr_req[1]), 0);
        chk("b0_req_c2", int'(tr_req[2]), 0);

        // grant withheld for the first two ADD cycles
        do_mul(16'd3, 16'd5, 0, 2, -1, -1, r, e, cyc, st);
        for (int k = 2; k <= 4; k++) begin
            chk($sformatf("stall_A_c%0d", k), int'(tr_A[k]), 0);
            chk($sformatf("stall_B_c%0d", k), int'(tr_B[k]), 3);
        end
        chk("stall_latency", cyc, 15);
        chk("stall_result", int'(r), 16'h000F);

        // start re-pulsed mid-run must be ignored
        do_mul(16'hFFFF, 16'hFFFF, 0, 0, -1, 20, r, e, cyc, st);
        chk("repulse_latency", cyc, 66);
        chk("repulse_result", int'(r), 16'h0001);

        // ALU error on first granted SHL (second granted op), then back-to-back start
        do_mul(16'd7, 16'd3, 0, 0, 1, -1, r, e, cyc, st);
        chk("aluerr_result", int'(r), 16'h0007);
        chk("aluerr_err", int'(e), 1);
        do_mul(16'd2, 16'd2, 0, 0, -1, -1, r, e, cyc, st);
        chk("after_err_result", int'(r), 16'h0004);
        chk("after_err_err", int'(e), 0);
        chk("after_err_latency", cyc, model_lat(16'd2));

        // reset asserted while in SRL
        start = 1'b1; a = 16'd3; b = 16'd5; alu_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (alu_req && alu_oper == 4'h7) found = 1;
            else begin @(posedge clk); #1; end
        end
        chk("rst_found_srl", found, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; alu_gnt = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_req", int'(alu_req), 0);
        chk("midrst_done", int'(done), 0);
        do_mul(16'd6, 16'd7, 0, 0, -1, -1, r, e, cyc, st);
        chk("midrst_next_result", int'(r), 16'h002A);

        // randomized operands with random grant stalls
        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom);
            rb = (i % 5 == 0) ? 16'($urandom_range(15)) : 16'($urandom);
            do_mul(ra, rb, 30, 0, -1, -1, r, e, cyc, st);
            chk($sformatf("rnd%0d_result a=%0h b=%0h", i, ra, rb), int'(r), int'(model_prod(ra, rb)));
            chk($sformatf("rnd%0d_latency", i), cyc, model_lat(rb) + st);
            chk($sformatf("rnd%0d_err", i), int'(e), 0);
        end

        chk("protocol_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
